// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time/alarm setting controller and the clock block.
// Holds the edit state encoding, time field limits and field stepping helpers.
package time_set_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_T_HOUR = 3'd1,
        ST_T_MIN  = 3'd2,
        ST_T_AMPM = 3'd3,
        ST_A_HOUR = 3'd4,
        ST_A_MIN  = 3'd5,
        ST_A_AMPM = 3'd6
    } state_e;

    localparam logic [3:0] HOUR_MIN = 4'd1;
    localparam logic [3:0] HOUR_MAX = 4'd12;
    localparam logic [5:0] MIN_MAX  = 6'd59;

    // Out-of-range values fall into the wrap branch, so any garbage recovers in one step.
    function automatic logic [3:0] next_hour(input logic [3:0] hour);
        return (hour >= HOUR_MIN && hour < HOUR_MAX) ? hour + 4'd1 : HOUR_MIN;
    endfunction

    function automatic logic [5:0] next_minute(input logic [5:0] minute);
        return (minute < MIN_MAX) ? minute + 6'd1 : 6'd0;
    endfunction

endpackage

// File: rtl/time_set_ctrl_button_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stable-level debouncer and
// a one-cycle pulse on the accepted rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press_out
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // cnt_q counts consecutive samples that disagree with the accepted level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        press_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_out = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time and alarm setting controller: three debounced buttons drive an edit FSM
// that commits either a set-time pulse to the clock block or a new alarm time.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TIMEOUT_CYCLES  = 10000
) (
    input  logic       clk_1khz,
    input  logic       reset_in,
    input  logic       mode_btn_in,
    input  logic       alarm_btn_in,
    input  logic       inc_btn_in,
    input  logic [3:0] hours_in,
    input  logic [5:0] minutes_in,
    input  logic [0:0] am_pm_in,
    output logic       set_time_out,
    output logic [3:0] set_hour_out,
    output logic [5:0] set_minute_out,
    output logic [0:0] set_ampm_out,
    output logic [3:0] alarm_hour_out,
    output logic [5:0] alarm_minute_out,
    output logic [0:0] alarm_ampm_out,
    output logic [2:0] state_out,
    output logic       edit_active_out
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic mode_p, alarm_p, inc_p;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk(clk_1khz), .rst(reset_in), .btn_in(mode_btn_in), .press_out(mode_p));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_alarm_db (
        .clk(clk_1khz), .rst(reset_in), .btn_in(alarm_btn_in), .press_out(alarm_p));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clk(clk_1khz), .rst(reset_in), .btn_in(inc_btn_in), .press_out(inc_p));

    state_e        state_q, state_d;
    logic [3:0]    edit_hour_q, edit_hour_d;
    logic [5:0]    edit_min_q, edit_min_d;
    logic          edit_ampm_q, edit_ampm_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          set_time_q, set_time_d;
    logic [3:0]    set_hour_q, set_hour_d, alarm_hour_q, alarm_hour_d;
    logic [5:0]    set_min_q, set_min_d, alarm_min_q, alarm_min_d;
    logic          set_ampm_q, set_ampm_d, alarm_ampm_q, alarm_ampm_d;
    logic          edit_active_q, edit_active_d;

    always_comb begin
        state_d      = state_q;
        edit_hour_d  = edit_hour_q;
        edit_min_d   = edit_min_q;
        edit_ampm_d  = edit_ampm_q;
        idle_d       = (state_q == ST_RUN) ? '0 : idle_q + IW'(1);
        set_time_d   = 1'b0;
        set_hour_d   = set_hour_q;
        set_min_d    = set_min_q;
        set_ampm_d   = set_ampm_q;
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        alarm_ampm_d = alarm_ampm_q;

        if (state_q == ST_RUN) begin
            if (mode_p) begin
                state_d     = ST_T_HOUR;
                edit_hour_d = hours_in;
                edit_min_d  = minutes_in;
                edit_ampm_d = am_pm_in[0];
            end else if (alarm_p) begin
                state_d     = ST_A_HOUR;
                edit_hour_d = alarm_hour_q;
                edit_min_d  = alarm_min_q;
                edit_ampm_d = alarm_ampm_q;
            end
        end else if (mode_p) begin
            // Mode wins over a coincident inc; the inc pulse is simply dropped.
            idle_d = '0;
            case (state_q)
                ST_T_HOUR: state_d = ST_T_MIN;
                ST_T_MIN:  state_d = ST_T_AMPM;
                ST_T_AMPM: begin
                    state_d    = ST_RUN;
                    set_time_d = 1'b1;
                    set_hour_d = edit_hour_q;
                    set_min_d  = edit_min_q;
                    set_ampm_d = edit_ampm_q;
                end
                ST_A_HOUR: state_d = ST_A_MIN;
                ST_A_MIN:  state_d = ST_A_AMPM;
                ST_A_AMPM: begin
                    state_d      = ST_RUN;
                    alarm_hour_d = edit_hour_q;
                    alarm_min_d  = edit_min_q;
                    alarm_ampm_d = edit_ampm_q;
                end
                default:   state_d = ST_RUN;
            endcase
        end else if (inc_p) begin
            idle_d = '0;
            case (state_q)
                ST_T_HOUR, ST_A_HOUR: edit_hour_d = next_hour(edit_hour_q);
                ST_T_MIN, ST_A_MIN:   edit_min_d  = next_minute(edit_min_q);
                ST_T_AMPM, ST_A_AMPM: edit_ampm_d = ~edit_ampm_q;
                default:              edit_ampm_d = edit_ampm_q;
            endcase
        end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_RUN;
        end

        edit_active_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk_1khz or posedge reset_in) begin
        if (reset_in) begin
            state_q       <= ST_RUN;
            edit_hour_q   <= '0;
            edit_min_q    <= '0;
            edit_ampm_q   <= 1'b0;
            idle_q        <= '0;
            set_time_q    <= 1'b0;
            set_hour_q    <= HOUR_MAX;
            set_min_q     <= '0;
            set_ampm_q    <= 1'b0;
            alarm_hour_q  <= HOUR_MAX;
            alarm_min_q   <= '0;
            alarm_ampm_q  <= 1'b0;
            edit_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            edit_hour_q   <= edit_hour_d;
            edit_min_q    <= edit_min_d;
            edit_ampm_q   <= edit_ampm_d;
            idle_q        <= idle_d;
            set_time_q    <= set_time_d;
            set_hour_q    <= set_hour_d;
            set_min_q     <= set_min_d;
            set_ampm_q    <= set_ampm_d;
            alarm_hour_q  <= alarm_hour_d;
            alarm_min_q   <= alarm_min_d;
            alarm_ampm_q  <= alarm_ampm_d;
            edit_active_q <= edit_active_d;
        end
    end

    assign set_time_out     = set_time_q;
    assign set_hour_out     = set_hour_q;
    assign set_minute_out   = set_min_q;
    assign set_ampm_out     = set_ampm_q;
    assign alarm_hour_out   = alarm_hour_q;
    assign alarm_minute_out = alarm_min_q;
    assign alarm_ampm_out   = alarm_ampm_q;
    assign state_out        = state_q;
    assign edit_active_out  = edit_active_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl; commit pulses are checked by a scoreboard monitor.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_btn, alarm_btn, inc_btn;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [0:0] am_pm;
    logic       set_time;
    logic [3:0] set_hour, alarm_hour;
    logic [5:0] set_min, alarm_min;
    logic [0:0] set_ampm, alarm_ampm;
    logic [2:0] state;
    logic       edit_active;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int h;
        int m;
        int a;
    } exp_t;
    exp_t exp_q[$];

    time_set_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
        .clk_1khz(clk), .reset_in(rst),
        .mode_btn_in(mode_btn), .alarm_btn_in(alarm_btn), .inc_btn_in(inc_btn),
        .hours_in(hours), .minutes_in(minutes), .am_pm_in(am_pm),
        .set_time_out(set_time), .set_hour_out(set_hour),
        .set_minute_out(set_min), .set_ampm_out(set_ampm),
        .alarm_hour_out(alarm_hour), .alarm_minute_out(alarm_min),
        .alarm_ampm_out(alarm_ampm), .state_out(state),
        .edit_active_out(edit_active));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic a, input logic i);
        @(negedge clk);
        mode_btn = m; alarm_btn = a; inc_btn = i;
        cycles(8);
        mode_btn = 1'b0; alarm_btn = 1'b0; inc_btn = 1'b0;
        cycles(8);
    endtask

    task automatic live(input int h, input int m, input int a);
        hours = 4'(h); minutes = 6'(m); am_pm = 1'(a);
    endtask

    task automatic chk_set(input string tag, input int h, input int m, input int a);
        chk({tag, "_set_hour"}, int'(set_hour), h);
        chk({tag, "_set_min"}, int'(set_min), m);
        chk({tag, "_set_ampm"}, int'(set_ampm), a);
    endtask

    task automatic chk_alarm(input string tag, input int h, input int m, input int a);
        chk({tag, "_alarm_hour"}, int'(alarm_hour), h);
        chk({tag, "_alarm_min"}, int'(alarm_min), m);
        chk({tag, "_alarm_ampm"}, int'(alarm_ampm), a);
    endtask

    // Scoreboard monitor: every commit pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (set_time === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: got set_time_out=1 expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_hour", int'(set_hour), e.h);
                    chk("pulse_min", int'(set_min), e.m);
                    chk("pulse_ampm", int'(set_ampm), e.a);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        mode_btn = 1'b0; alarm_btn = 1'b0; inc_btn = 1'b0;
        live(0, 0, 0);
        cycles(3);
        chk("rst_state", int'(state), 0);
        chk("rst_set_time", int'(set_time), 0);
        chk("rst_edit_active", int'(edit_active), 0);
        chk_set("rst", 12, 0, 0);
        chk_alarm("rst", 12, 0, 0);
        rst = 1'b0;
        cycles(2);

        // 11:59 PM rolls every field over to 12:00 AM
        live(11, 59, 1);
        press(1, 0, 0);
        chk("a_state_thour", int'(state), 1);
        chk("a_edit_active", int'(edit_active), 1);
        press(0, 0, 1);
        press(1, 0, 0);
        chk("a_state_tmin", int'(state), 2);
        press(0, 0, 1);
        press(1, 0, 0);
        chk("a_state_tampm", int'(state), 3);
        press(0, 0, 1);
        exp_q.push_back('{12, 0, 0});
        press(1, 0, 0);
        chk("a_state_run", int'(state), 0);
        chk("a_edit_idle", int'(edit_active), 0);
        chk_set("a", 12, 0, 0);

        // 3:07 AM -> 3:08 PM
        live(3, 7, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        exp_q.push_back('{3, 8, 1});
        press(1, 0, 0);
        chk_set("b", 3, 8, 1);

        // Alarm: 13 incs from 12 wrap through to 1, commit without a set pulse
        press(0, 1, 0);
        chk("c_state_ahour", int'(state), 4);
        repeat (13) press(0, 0, 1);
        press(1, 0, 0);
        chk("c_state_amin", int'(state), 5);
        press(1, 0, 0);
        chk("c_state_aampm", int'(state), 6);
        press(1, 0, 0);
        chk("c_state_run", int'(state), 0);
        chk_alarm("c", 1, 0, 0);
        chk_set("c_hold", 3, 8, 1);

        // Alarm edit reloads from committed alarm: 1:00 AM -> 2:02 PM
        press(0, 1, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        chk_alarm("d", 2, 2, 1);

        // Out-of-range live time steps to 1 and 0
        live(15, 62, 0);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        exp_q.push_back('{1, 0, 0});
        press(1, 0, 0);
        chk_set("e", 1, 0, 0);

        // Alarm ignored in edit, mode+inc together applies mode only
        live(5, 30, 1);
        press(1, 0, 0);
        press(0, 1, 0);
        chk("f_alarm_ignored", int'(state), 1);
        press(1, 0, 1);
        chk("f_simul_state", int'(state), 2);
        press(1, 0, 0);
        exp_q.push_back('{5, 30, 1});
        press(1, 0, 0);
        chk_set("f", 5, 30, 1);

        // Inc in RUN is ignored
        press(0, 0, 1);
        chk("g_inc_run_state", int'(state), 0);
        chk("g_inc_run_active", int'(edit_active), 0);

        // Idle timeout in T_MIN abandons the edit
        live(9, 15, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 0, 1);
        cycles(30);
        chk("h_before_timeout", int'(state), 2);
        cycles(20);
        chk("h_after_timeout", int'(state), 0);
        chk("h_edit_active", int'(edit_active), 0);
        chk_set("h", 5, 30, 1);
        chk_alarm("h", 2, 2, 1);

        // Bounce shorter than the debounce window is not a press
        repeat (3) begin
            mode_btn = 1'b1; cycles(2);
            mode_btn = 1'b0; cycles(2);
        end
        cycles(10);
        chk("i_bounce_state", int'(state), 0);

        // Reset mid-edit abandons it and restores reset values
        live(7, 45, 1);
        press(1, 0, 0);
        chk("j_state_thour", int'(state), 1);
        press(0, 0, 1);
        rst = 1'b1;
        cycles(2);
        chk("j_rst_state", int'(state), 0);
        chk("j_rst_set_time", int'(set_time), 0);
        chk("j_rst_edit_active", int'(edit_active), 0);
        chk_set("j", 12, 0, 0);
        chk_alarm("j", 12, 0, 0);
        rst = 1'b0;
        cycles(5);
        chk("j_post_state", int'(state), 0);

        cycles(5);
        chk("pending_pulses", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20: consecutive stable samples required to accept a button level change.
REQ-002 Parameter TIMEOUT_CYCLES, default 10000: cycles without a press before an edit aborts (10 s at 1 kHz).
REQ-003 Clk_1khz  input  1: single clock, all logic rising-edge.
REQ-004 reset_in  input  1: asynchronous, active-high reset.
REQ-005 mode_btn_in, alarm_btn_in, inc_btn_in  input  1 each: raw asynchronous push-buttons, active-high.
REQ-006 hours_in [3:0], minutes_in [5:0], am_pm_in [0:0]  input: live time from the clock block.
REQ-007 set_time_out  output  1: one-cycle commit pulse to the clock's set-time input.
REQ-008 set_hour_out [3:0], set_minute_out [5:0], set_ampm_out [0:0]  output: time value presented with set_time_out.
REQ-009 alarm_hour_out [3:0], alarm_minute_out [5:0], alarm_ampm_out [0:0]  output: committed alarm time.
REQ-010 state_out  output  3: current FSM state encoding, used for display blinking.
REQ-011 edit_active_out  output  1: high in any state other than RUN.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced rising edge SHALL yield a one-cycle press pulse.
REQ-013 FSM states SHALL be RUN, T_HOUR, T_MIN, T_AMPM, A_HOUR, A_MIN and A_AMPM.
REQ-014 In RUN, a mode press SHALL go to T_HOUR and load edit registers from hours_in, minutes_in and am_pm_in on that cycle.
REQ-015 In RUN, an alarm press SHALL go to A_HOUR and load edit registers from the alarm_* outputs.
REQ-016 In RUN, inc presses SHALL be ignored; in edit states, alarm presses SHALL be ignored.
REQ-017 A mode press SHALL advance T_HOUR->T_MIN->T_AMPM->RUN and A_HOUR->A_MIN->A_AMPM->RUN.
REQ-018 An inc press in a HOUR state SHALL step the hour 1..12 and wrap 12->1; values outside 1..12 loaded on entry SHALL step to 1.
REQ-019 An inc press in a MIN state SHALL step the minute 0..59 and wrap 59->0; values above 59 SHALL step to 0.
REQ-020 An inc press in an AMPM state SHALL toggle the AM/PM bit.
REQ-021 A mode press in T_AMPM SHALL register the edited values onto set_*_out and assert set_time_out for exactly the next cycle.
REQ-022 set_*_out SHALL hold their values until the next time commit.
REQ-023 A mode press in A_AMPM SHALL update alarm_*_out on the next cycle; set_time_out SHALL stay low.
REQ-024 A simultaneous mode press and inc press SHALL apply mode only; the inc press SHALL be discarded.
REQ-025 An idle counter SHALL clear on any accepted press and on state entry.
REQ-026 When the idle counter reaches TIMEOUT_CYCLES in an edit state, the FSM SHALL return to RUN with no commit and no output change.
REQ-027 set_time_out SHALL never assert other than via REQ-021.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While reset_in is high, the FSM SHALL be RUN and set_time_out 0.
REQ-030 While reset_in is high, set_hour_out and alarm_hour_out SHALL be 12, set_minute_out and alarm_minute_out 0, and set_ampm_out and alarm_ampm_out 0.
REQ-031 While reset_in is high, debouncer state, edit registers and the idle counter SHALL be 0.
REQ-032 A reset during an edit SHALL abandon the edit with no commit pulse.

Structure
REQ-033 A shared package SHALL hold the state enum, HOUR_MIN=1, HOUR_MAX=12 and MIN_MAX=59, shared with the clock block.
REQ-034 One sub-module, button_debounce (synchronizer, debouncer, edge pulse), SHALL be instantiated three times.

Verification
REQ-035 Apply reset -> alarm 12:00 AM, set_* 12:00 AM, set_time_out 0, state RUN.
REQ-036 With live time 11:59 PM (DEBOUNCE_CYCLES=4): mode, inc, mode, inc, mode, inc, mode -> one set_time_out pulse with 12:00 AM.
REQ-037 Alarm press, then 13 inc presses from hour 12 -> hour passes 1..12 and ends at 1; full commit -> alarm_hour_out 1.
REQ-038 Mode and inc pressed in the same cycle in T_HOUR -> state T_MIN, hour unchanged.
REQ-039 TIMEOUT_CYCLES=50: enter T_MIN, inc, then idle 50 cycles -> RUN, no pulse, set_* unchanged.
REQ-040 Button bounce shorter than DEBOUNCE_CYCLES -> no press; reset_in asserted mid-edit -> RUN, outputs at reset values.
